// File: rtl/fifo_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM state encoding
// and the serial line levels.
package fifo_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        WAIT  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } TxState;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses tick on the last
// count of each bit period; clear holds it at zero between frames.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign tick = !clear && (count_q == LAST);

    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clear || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from an upstream FIFO and sends them as
// 8N1 (or 8N2) frames, LSB first, with the line idling high.
module fifo_uart_tx
    import fifo_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_pop,
    output logic       tx,
    output logic       busy
);

    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    TxState     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bitIdx_q, bitIdx_d;
    logic       tx_q, tx_d;
    logic       tick;
    logic       clearCnt;
    logic       startOk;

    assign startOk = enable && !fifo_empty;
    assign tx      = tx_q;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clear(clearCnt),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bitIdx_q <= '0;
            tx_q     <= IDLE_LEVEL;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitIdx_q <= bitIdx_d;
            tx_q     <= tx_d;
        end
    end

    // bitIdx doubles as the stop-bit counter, so it is back at zero on leaving STOP
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitIdx_d = bitIdx_q;
        unique case (state_q)
            IDLE: begin
                if (startOk) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = WAIT;
            end
            WAIT: begin
                shift_d = fifo_data;
                state_d = START;
            end
            START: begin
                if (tick) begin
                    bitIdx_d = '0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d  = {1'b0, shift_q[7:1]};
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (bitIdx_q == LAST_STOP) begin
                        bitIdx_d = '0;
                        state_d  = startOk ? POP : IDLE;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // tx is registered from the upcoming state so the line level lines up with the state
    always_comb begin
        tx_d     = IDLE_LEVEL;
        clearCnt = (state_q == IDLE) || (state_q == POP) || (state_q == WAIT);
        fifo_pop = (state_q == POP);
        busy     = (state_q != IDLE);
        case (state_d)
            START:   tx_d = START_LEVEL;
            DATA:    tx_d = shift_d[0];
            default: tx_d = IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: stimulus queues expected bytes, a line
// monitor decodes each frame cycle by cycle and compares it to the queue.
module tb_fifo_uart_tx;

    localparam int CPB      = 4;
    localparam int FRAME_CY = 10 * CPB;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] fifoMem [0:15];
    logic [3:0] wrPtr = 4'd0;
    logic [3:0] rdPtr = 4'd0;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_pop, tx, busy;

    logic       enable2 = 1'b0;
    logic       empty2  = 1'b1;
    logic [7:0] data2   = 8'h00;
    logic       pop2, tx2, busy2;

    int checks = 0;
    int errors = 0;
    int popCount = 0;
    int busyCycles = 0;
    int busy2Cycles = 0;
    int runHigh2 = 0;
    int lastGap = 0;
    logic [7:0] expQ[$];

    assign fifo_empty = (wrPtr == rdPtr);

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_pop(fifo_pop), .tx(tx), .busy(busy)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .enable(enable2), .fifo_empty(empty2),
        .fifo_data(data2), .fifo_pop(pop2), .tx(tx2), .busy(busy2)
    );

    always #5 clk = ~clk;

    // Upstream FIFO model: registered read data, updated on the pop edge
    always @(posedge clk) begin
        if (fifo_pop) begin
            fifo_data <= fifoMem[rdPtr];
            rdPtr     <= rdPtr + 4'd1;
            popCount  <= popCount + 1;
        end
    end

    always @(negedge clk) begin
        if (busy) busyCycles <= busyCycles + 1;
        if (busy2) begin
            busy2Cycles <= busy2Cycles + 1;
            runHigh2    <= tx2 ? runHigh2 + 1 : 0;
        end
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting on DUT", name);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        fifoMem[wrPtr] = b;
        wrPtr = wrPtr + 4'd1;
        expQ.push_back(b);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitFrameDone(input string name);
        int n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!busy) begin
            reportTimeout({name, " busy rise"});
            return;
        end
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy) reportTimeout({name, " busy fall"});
    endtask

    task automatic waitTxLow(input string name);
        int n = 0;
        while (tx !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) reportTimeout({name, " start bit"});
    endtask

    function automatic logic [FRAME_CY-1:0] expWave(input logic [7:0] b);
        logic [FRAME_CY-1:0] w;
        for (int i = 0; i < FRAME_CY; i++) begin
            int k = i / CPB;
            if (k == 0)      w[i] = 1'b0;
            else if (k == 9) w[i] = 1'b1;
            else             w[i] = b[k-1];
        end
        return w;
    endfunction

    // Line monitor: captures every frame sample-by-sample and scores it
    initial begin
        logic [FRAME_CY-1:0] frame;
        logic [7:0] expByte;
        bit collecting = 1'b0;
        int sIdx = 0;
        int idleRun = 0;
        frame = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (collecting && expQ.size() > 0) expByte = expQ.pop_front();
                collecting = 1'b0;
                idleRun = 0;
            end else if (collecting) begin
                frame[sIdx] = tx;
                sIdx++;
                if (sIdx == FRAME_CY) begin
                    collecting = 1'b0;
                    idleRun = 0;
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected frame: got 0x%0h, expected no frame", frame);
                    end else begin
                        expByte = expQ.pop_front();
                        checkOutput($sformatf("frame 0x%02h", expByte),
                                    longint'(frame), longint'(expWave(expByte)));
                    end
                end
            end else if (tx === 1'b0) begin
                collecting = 1'b1;
                frame = '0;
                sIdx = 1;
                lastGap = idleRun;
            end else begin
                idleRun++;
            end
        end
    end

    initial begin
        int p0, b0, bad, n;

        waitCycles(2);
        checkOutput("reset tx", longint'(tx), 1);
        checkOutput("reset busy", longint'(busy), 0);
        checkOutput("reset fifo_pop", longint'(fifo_pop), 0);
        reset = 1'b1;
        waitCycles(2);

        $display("[TB] empty FIFO with enable high");
        enable = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || fifo_pop !== 1'b0 || busy !== 1'b0) bad++;
        end
        checkOutput("empty idle violations", longint'(bad), 0);

        $display("[TB] single byte 0x55");
        p0 = popCount;
        b0 = busyCycles;
        applyStimulus(8'h55);
        waitFrameDone("0x55");
        waitCycles(3);
        checkOutput("0x55 pop pulses", longint'(popCount - p0), 1);
        checkOutput("0x55 busy cycles", longint'(busyCycles - b0), 42);

        $display("[TB] back-to-back 0xA5 0x3C");
        p0 = popCount;
        b0 = busyCycles;
        applyStimulus(8'hA5);
        applyStimulus(8'h3C);
        waitFrameDone("0xA5/0x3C");
        waitCycles(3);
        checkOutput("b2b pop pulses", longint'(popCount - p0), 2);
        checkOutput("b2b busy cycles", longint'(busyCycles - b0), 84);
        checkOutput("b2b idle gap", longint'(lastGap), 2);

        $display("[TB] enable dropped during start of 0x81");
        p0 = popCount;
        applyStimulus(8'h81);
        applyStimulus(8'h42);
        waitTxLow("0x81");
        enable = 1'b0;
        waitFrameDone("0x81");
        waitCycles(20);
        checkOutput("held pop count", longint'(popCount - p0), 1);
        checkOutput("held busy", longint'(busy), 0);
        enable = 1'b1;
        waitFrameDone("0x42");
        waitCycles(3);
        checkOutput("resumed pop count", longint'(popCount - p0), 2);

        $display("[TB] reset during data bit 3 of 0xFF");
        p0 = popCount;
        applyStimulus(8'hFF);
        waitTxLow("0xFF");
        waitCycles(17);
        #2 reset = 1'b0;
        #1;
        checkOutput("async reset tx", longint'(tx), 1);
        checkOutput("async reset busy", longint'(busy), 0);
        checkOutput("async reset fifo_pop", longint'(fifo_pop), 0);
        waitCycles(3);
        reset = 1'b1;
        waitCycles(20);
        checkOutput("post-reset pop count", longint'(popCount - p0), 1);
        applyStimulus(8'h5A);
        waitFrameDone("0x5A");
        waitCycles(3);
        checkOutput("post-reset resume pops", longint'(popCount - p0), 2);

        $display("[TB] two stop bits, byte 0x00");
        enable2 = 1'b1;
        empty2 = 1'b0;
        n = 0;
        while (pop2 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        empty2 = 1'b1;
        if (pop2 !== 1'b1) reportTimeout("stop2 pop");
        n = 0;
        while (busy2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy2) reportTimeout("stop2 busy fall");
        waitCycles(3);
        checkOutput("stop2 busy cycles", longint'(busy2Cycles), 46);
        checkOutput("stop2 final high run", longint'(runHigh2), 8);

        waitCycles(10);
        checkOutput("scoreboard drained", longint'(expQ.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
